// File: rtl/cpu_fetch_if.sv
// RAM bus between the fetch datapath (master) and program/stack memory (slave).
interface cpu_fetch_if;
   logic [7:0] mem_addr;
   logic [7:0] mem_rdata;
   logic [7:0] mem_wdata;
   logic       mem_we;

   modport master (output mem_addr, output mem_we, output mem_wdata, input mem_rdata);
   modport slave  (input mem_addr, input mem_we, input mem_wdata, output mem_rdata);
endinterface

// File: rtl/cpu_fetch.sv
// Program-sequencing datapath: PC, IR, MAR, TMP and SP driven by the sequencer's state code.
// Optional stack over/underflow guard enabled by defining CPU_FETCH_STACK_GUARD_EN.
module cpu_fetch #(
   parameter logic [7:0] SP_INIT = 8'hFF,
   parameter logic [7:0] PC_INIT = 8'h00
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [7:0]  state,
   input  logic        flag_z,
   input  logic        flag_c,
   cpu_fetch_if.master mem,
   output logic [7:0]  opcode,
   output logic [7:0]  pc,
   output logic [7:0]  sp,
   output logic        halted,
   output logic        stack_fault
);

   localparam logic [7:0] STATE_NEXT       = 8'h00;
   localparam logic [7:0] STATE_FETCH_PC   = 8'h01;
   localparam logic [7:0] STATE_FETCH_INST = 8'h02;
   localparam logic [7:0] STATE_JUMP       = 8'h03;
   localparam logic [7:0] STATE_LDI        = 8'h04;
   localparam logic [7:0] STATE_TMP_STORE  = 8'h05;
   localparam logic [7:0] STATE_FETCH_SP   = 8'h06;
   localparam logic [7:0] STATE_PC_STORE   = 8'h07;
   localparam logic [7:0] STATE_TMP_JUMP   = 8'h08;
   localparam logic [7:0] STATE_INC_SP     = 8'h09;
   localparam logic [7:0] STATE_RET        = 8'h0A;
   localparam logic [7:0] STATE_HALT       = 8'h0B;
   localparam logic [7:0] STATE_OUT_A      = 8'h0C;
   localparam logic [7:0] STATE_MOV_AB     = 8'h0D;
   localparam logic [7:0] STATE_MOV_BA     = 8'h0E;
   localparam logic [7:0] STATE_ALU_OP     = 8'h10;

   localparam logic [7:0] OP_RET = 8'h19;

   logic [7:0] pc_q, pc_d;
   logic [7:0] sp_q, sp_d;
   logic [7:0] ir_q, ir_d;
   logic [7:0] mar_q, mar_d;
   logic [7:0] tmp_q, tmp_d;
   logic [7:0] wdata_q, wdata_d;
   logic       we_q, we_d;
   logic       halted_q, halted_d;
   logic       jump_taken;

`ifdef CPU_FETCH_STACK_GUARD_EN
   logic fault_q, fault_d;
   assign stack_fault = fault_q;
`else
   assign stack_fault = 1'b0;
`endif

   always_comb begin
      unique case (ir_q[2:0])
         3'b000:  jump_taken = 1'b1;
         3'b001:  jump_taken = flag_z;
         3'b010:  jump_taken = ~flag_z;
         3'b011:  jump_taken = flag_c;
         3'b100:  jump_taken = ~flag_c;
         default: jump_taken = 1'b0;
      endcase
   end

   always_comb begin
      pc_d     = pc_q;
      sp_d     = sp_q;
      ir_d     = ir_q;
      mar_d    = mar_q;
      tmp_d    = tmp_q;
      wdata_d  = wdata_q;
      we_d     = 1'b0;
      halted_d = halted_q;
`ifdef CPU_FETCH_STACK_GUARD_EN
      fault_d  = fault_q;
`endif
      // A halted core ignores the sequencer entirely until reset.
      if (!halted_q) begin
         case (state)
            STATE_FETCH_PC:   mar_d = pc_q;
            STATE_FETCH_INST: begin
               ir_d = mem.mem_rdata;
               pc_d = pc_q + 8'd1;
            end
            STATE_JUMP:       pc_d = jump_taken ? mem.mem_rdata : pc_q + 8'd1;
            STATE_LDI:        pc_d = pc_q + 8'd1;
            STATE_TMP_STORE: begin
               tmp_d = mem.mem_rdata;
               pc_d  = pc_q + 8'd1;
            end
            STATE_FETCH_SP: begin
               mar_d = sp_q;
               if (ir_q != OP_RET) wdata_d = pc_q;
            end
            STATE_PC_STORE: begin
`ifdef CPU_FETCH_STACK_GUARD_EN
               if (sp_q == 8'h00) begin
                  fault_d = 1'b1;
               end else begin
                  we_d = 1'b1;
                  sp_d = sp_q - 8'd1;
               end
`else
               we_d = 1'b1;
               sp_d = sp_q - 8'd1;
`endif
            end
            STATE_TMP_JUMP:   pc_d = tmp_q;
            STATE_INC_SP: begin
`ifdef CPU_FETCH_STACK_GUARD_EN
               if (sp_q == 8'hFF) fault_d = 1'b1;
               else               sp_d    = sp_q + 8'd1;
`else
               sp_d = sp_q + 8'd1;
`endif
            end
            STATE_RET:        pc_d = mem.mem_rdata;
            STATE_HALT:       halted_d = 1'b1;
            STATE_NEXT, STATE_OUT_A, STATE_MOV_AB, STATE_MOV_BA, STATE_ALU_OP: ;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         pc_q     <= PC_INIT;
         sp_q     <= SP_INIT;
         ir_q     <= 8'h00;
         mar_q    <= 8'h00;
         tmp_q    <= 8'h00;
         wdata_q  <= 8'h00;
         we_q     <= 1'b0;
         halted_q <= 1'b0;
      end else begin
         pc_q     <= pc_d;
         sp_q     <= sp_d;
         ir_q     <= ir_d;
         mar_q    <= mar_d;
         tmp_q    <= tmp_d;
         wdata_q  <= wdata_d;
         we_q     <= we_d;
         halted_q <= halted_d;
      end
   end

`ifdef CPU_FETCH_STACK_GUARD_EN
   always_ff @(posedge clk) begin
      if (!reset_n) fault_q <= 1'b0;
      else          fault_q <= fault_d;
   end
`endif

   assign mem.mem_addr  = mar_q;
   assign mem.mem_we    = we_q;
   assign mem.mem_wdata = wdata_q;
   assign opcode        = ir_q;
   assign pc            = pc_q;
   assign sp            = sp_q;
   assign halted        = halted_q;

endmodule

// File: tb/tb_cpu_fetch.sv
// Self-checking bench for cpu_fetch: vector table plus hand sequences, checked through a queue.
module tb_cpu_fetch;

   localparam logic [7:0] S_NEXT       = 8'h00;
   localparam logic [7:0] S_FETCH_PC   = 8'h01;
   localparam logic [7:0] S_FETCH_INST = 8'h02;
   localparam logic [7:0] S_JUMP       = 8'h03;
   localparam logic [7:0] S_LDI        = 8'h04;
   localparam logic [7:0] S_TMP_STORE  = 8'h05;
   localparam logic [7:0] S_FETCH_SP   = 8'h06;
   localparam logic [7:0] S_PC_STORE   = 8'h07;
   localparam logic [7:0] S_TMP_JUMP   = 8'h08;
   localparam logic [7:0] S_INC_SP     = 8'h09;
   localparam logic [7:0] S_RET        = 8'h0A;
   localparam logic [7:0] S_HALT       = 8'h0B;
   localparam logic [7:0] S_OUT_A      = 8'h0C;
   localparam logic [7:0] S_ALU_OP     = 8'h10;

`ifdef CPU_FETCH_STACK_GUARD_EN
   localparam bit GUARD = 1'b1;
`else
   localparam bit GUARD = 1'b0;
`endif

   typedef struct packed {
      logic       rn;
      logic [7:0] st;
      logic       z;
      logic       c;
      logic [7:0] pc;
      logic [7:0] sp;
      logic [7:0] op;
      logic [7:0] addr;
      logic       we;
      logic [7:0] wd;
      logic       halt;
      logic       sf;
   } vec_t;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [7:0] state;
   logic       flag_z, flag_c;
   logic [7:0] opcode, pc, sp;
   logic       halted, stack_fault;
   logic [7:0] mem [256];

   int   checks = 0;
   int   errors = 0;
   vec_t sb_q[$];
   vec_t tbl[32];

   cpu_fetch_if bus ();

   cpu_fetch dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .state       (state),
      .flag_z      (flag_z),
      .flag_c      (flag_c),
      .mem         (bus),
      .opcode      (opcode),
      .pc          (pc),
      .sp          (sp),
      .halted      (halted),
      .stack_fault (stack_fault)
   );

   always #5 clk = ~clk;

   assign bus.mem_rdata = mem[bus.mem_addr];

   always @(posedge clk) begin
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
   end

   function automatic vec_t mk(input logic rn, input logic [7:0] st, input logic z, input logic c,
                               input logic [7:0] epc, input logic [7:0] esp,
                               input logic [7:0] eop, input logic [7:0] eaddr,
                               input logic ewe, input logic [7:0] ewd,
                               input logic ehalt, input logic esf);
      vec_t v;
      v.rn = rn; v.st = st; v.z = z; v.c = c;
      v.pc = epc; v.sp = esp; v.op = eop; v.addr = eaddr;
      v.we = ewe; v.wd = ewd; v.halt = ehalt; v.sf = esf;
      return v;
   endfunction

   task automatic check(input string tag, input string name, input logic [7:0] act,
                        input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s %s actual=%h required=%h", tag, name, act, exp);
      end
   endtask

   task automatic step(input string tag, input vec_t v);
      vec_t e;
      reset_n = v.rn;
      state   = v.st;
      flag_z  = v.z;
      flag_c  = v.c;
      sb_q.push_back(v);
      @(posedge clk);
      #1;
      e = sb_q.pop_front();
      check(tag, "pc", pc, e.pc);
      check(tag, "sp", sp, e.sp);
      check(tag, "opcode", opcode, e.op);
      check(tag, "mem_addr", bus.mem_addr, e.addr);
      check(tag, "mem_we", {7'd0, bus.mem_we}, {7'd0, e.we});
      check(tag, "mem_wdata", bus.mem_wdata, e.wd);
      check(tag, "halted", {7'd0, halted}, {7'd0, e.halt});
      check(tag, "stack_fault", {7'd0, stack_fault}, {7'd0, e.sf});
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      mem[8'h00] = 8'h3A;
      mem[8'h01] = 8'h40;
      mem[8'h06] = 8'h18;
      mem[8'h07] = 8'h10;
      mem[8'h10] = 8'h80;
      mem[8'h3A] = 8'hFF;
      mem[8'h40] = 8'h31;
      mem[8'h41] = 8'h05;
      mem[8'h80] = 8'h19;

      reset_n = 1'b0;
      state   = S_NEXT;
      flag_z  = 1'b0;
      flag_c  = 1'b0;

      //                 rn st            z  c  pc     sp     op     addr   we wd     h  sf
      tbl[0]  = mk(1, S_FETCH_PC,   0, 0, 8'h00, 8'hFF, 8'h00, 8'h00, 0, 8'h00, 0, 0);
      tbl[1]  = mk(1, S_FETCH_INST, 0, 0, 8'h01, 8'hFF, 8'h3A, 8'h00, 0, 8'h00, 0, 0);
      tbl[2]  = mk(1, S_FETCH_PC,   0, 0, 8'h01, 8'hFF, 8'h3A, 8'h01, 0, 8'h00, 0, 0);
      tbl[3]  = mk(1, S_JUMP,       0, 0, 8'h40, 8'hFF, 8'h3A, 8'h01, 0, 8'h00, 0, 0);
      tbl[4]  = mk(1, S_FETCH_PC,   0, 0, 8'h40, 8'hFF, 8'h3A, 8'h40, 0, 8'h00, 0, 0);
      tbl[5]  = mk(1, S_FETCH_INST, 0, 0, 8'h41, 8'hFF, 8'h31, 8'h40, 0, 8'h00, 0, 0);
      tbl[6]  = mk(1, S_FETCH_PC,   0, 0, 8'h41, 8'hFF, 8'h31, 8'h41, 0, 8'h00, 0, 0);
      tbl[7]  = mk(1, S_JUMP,       1, 0, 8'h05, 8'hFF, 8'h31, 8'h41, 0, 8'h00, 0, 0);
      tbl[8]  = mk(1, S_JUMP,       0, 1, 8'h06, 8'hFF, 8'h31, 8'h41, 0, 8'h00, 0, 0);
      tbl[9]  = mk(1, S_JUMP,       1, 1, 8'h05, 8'hFF, 8'h31, 8'h41, 0, 8'h00, 0, 0);
      tbl[10] = mk(1, S_LDI,        0, 0, 8'h06, 8'hFF, 8'h31, 8'h41, 0, 8'h00, 0, 0);
      tbl[11] = mk(1, S_OUT_A,      0, 0, 8'h06, 8'hFF, 8'h31, 8'h41, 0, 8'h00, 0, 0);
      tbl[12] = mk(1, S_ALU_OP,     1, 1, 8'h06, 8'hFF, 8'h31, 8'h41, 0, 8'h00, 0, 0);
      tbl[13] = mk(1, 8'hEE,        1, 0, 8'h06, 8'hFF, 8'h31, 8'h41, 0, 8'h00, 0, 0);
      tbl[14] = mk(1, S_FETCH_PC,   0, 0, 8'h06, 8'hFF, 8'h31, 8'h06, 0, 8'h00, 0, 0);
      tbl[15] = mk(1, S_FETCH_INST, 0, 0, 8'h07, 8'hFF, 8'h18, 8'h06, 0, 8'h00, 0, 0);
      tbl[16] = mk(1, S_FETCH_PC,   0, 0, 8'h07, 8'hFF, 8'h18, 8'h07, 0, 8'h00, 0, 0);
      tbl[17] = mk(1, S_JUMP,       0, 0, 8'h10, 8'hFF, 8'h18, 8'h07, 0, 8'h00, 0, 0);
      tbl[18] = mk(1, S_FETCH_PC,   0, 0, 8'h10, 8'hFF, 8'h18, 8'h10, 0, 8'h00, 0, 0);
      tbl[19] = mk(1, S_TMP_STORE,  0, 0, 8'h11, 8'hFF, 8'h18, 8'h10, 0, 8'h00, 0, 0);
      tbl[20] = mk(1, S_FETCH_SP,   0, 0, 8'h11, 8'hFF, 8'h18, 8'hFF, 0, 8'h11, 0, 0);
      tbl[21] = mk(1, S_PC_STORE,   0, 0, 8'h11, 8'hFE, 8'h18, 8'hFF, 1, 8'h11, 0, 0);
      tbl[22] = mk(1, S_TMP_JUMP,   0, 0, 8'h80, 8'hFE, 8'h18, 8'hFF, 0, 8'h11, 0, 0);
      tbl[23] = mk(1, S_FETCH_PC,   0, 0, 8'h80, 8'hFE, 8'h18, 8'h80, 0, 8'h11, 0, 0);
      tbl[24] = mk(1, S_FETCH_INST, 0, 0, 8'h81, 8'hFE, 8'h19, 8'h80, 0, 8'h11, 0, 0);
      tbl[25] = mk(1, S_INC_SP,     0, 0, 8'h81, 8'hFF, 8'h19, 8'h80, 0, 8'h11, 0, 0);
      tbl[26] = mk(1, S_FETCH_SP,   0, 0, 8'h81, 8'hFF, 8'h19, 8'hFF, 0, 8'h11, 0, 0);
      tbl[27] = mk(1, S_RET,        0, 0, 8'h11, 8'hFF, 8'h19, 8'hFF, 0, 8'h11, 0, 0);
      tbl[28] = mk(1, S_NEXT,       0, 0, 8'h11, 8'hFF, 8'h19, 8'hFF, 0, 8'h11, 0, 0);
      tbl[29] = mk(1, S_HALT,       0, 0, 8'h11, 8'hFF, 8'h19, 8'hFF, 0, 8'h11, 1, 0);
      tbl[30] = mk(1, S_FETCH_INST, 0, 0, 8'h11, 8'hFF, 8'h19, 8'hFF, 0, 8'h11, 1, 0);
      tbl[31] = mk(1, S_FETCH_PC,   0, 0, 8'h11, 8'hFF, 8'h19, 8'hFF, 0, 8'h11, 1, 0);

      step("reset", mk(0, S_NEXT, 0, 0, 8'h00, 8'hFF, 8'h00, 8'h00, 0, 8'h00, 0, 0));
      for (int i = 0; i < 32; i++) step($sformatf("vec%0d", i), tbl[i]);

      // Reset while halted clears everything, including halted.
      step("rst_halt", mk(0, S_HALT, 0, 0, 8'h00, 8'hFF, 8'h00, 8'h00, 0, 8'h00, 0, 0));

      // Reset between TMP_STORE and PC_STORE must swallow the push.
      step("call_tmp", mk(1, S_TMP_STORE, 0, 0, 8'h01, 8'hFF, 8'h00, 8'h00, 0, 8'h00, 0, 0));
      step("call_sp",  mk(1, S_FETCH_SP,  0, 0, 8'h01, 8'hFF, 8'h00, 8'hFF, 0, 8'h01, 0, 0));
      step("call_rst", mk(0, S_PC_STORE,  0, 0, 8'h00, 8'hFF, 8'h00, 8'h00, 0, 8'h00, 0, 0));
      step("call_idl", mk(1, S_NEXT,      0, 0, 8'h00, 8'hFF, 8'h00, 8'h00, 0, 8'h00, 0, 0));

      // PC wrap: IR=0 means unconditional jump; reach PC=FF then increment.
      step("wrap_j1",  mk(1, S_JUMP,     0, 0, 8'h3A, 8'hFF, 8'h00, 8'h00, 0, 8'h00, 0, 0));
      step("wrap_pc",  mk(1, S_FETCH_PC, 0, 0, 8'h3A, 8'hFF, 8'h00, 8'h3A, 0, 8'h00, 0, 0));
      step("wrap_j2",  mk(1, S_JUMP,     0, 0, 8'hFF, 8'hFF, 8'h00, 8'h3A, 0, 8'h00, 0, 0));
      step("wrap_inc", mk(1, S_LDI,      0, 0, 8'h00, 8'hFF, 8'h00, 8'h3A, 0, 8'h00, 0, 0));

      // Drain the stack down to SP=00, then push once more.
      step("g_rst", mk(0, S_NEXT, 0, 0, 8'h00, 8'hFF, 8'h00, 8'h00, 0, 8'h00, 0, 0));
      for (int i = 0; i < 255; i++) begin
         logic [7:0] esp;
         esp = 8'hFE - 8'(i);
         step($sformatf("push%0d", i),
              mk(1, S_PC_STORE, 0, 0, 8'h00, esp, 8'h00, 8'h00, 1, 8'h00, 0, 0));
      end
      step("g_push", mk(1, S_PC_STORE, 0, 0, 8'h00, GUARD ? 8'h00 : 8'hFF, 8'h00, 8'h00,
                        !GUARD, 8'h00, 0, GUARD));
      step("g_hold", mk(1, S_NEXT, 0, 0, 8'h00, GUARD ? 8'h00 : 8'hFF, 8'h00, 8'h00,
                        0, 8'h00, 0, GUARD));
      step("g_rst2", mk(0, S_NEXT, 0, 0, 8'h00, 8'hFF, 8'h00, 8'h00, 0, 8'h00, 0, 0));
      step("g_pop",  mk(1, S_INC_SP, 0, 0, 8'h00, GUARD ? 8'hFF : 8'h00, 8'h00, 8'h00,
                        0, 8'h00, 0, GUARD));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/cpu_fetch.md
Name: cpu_fetch

Overview:
- Program-sequencing datapath that feeds the opcode to the CPU control sequencer and consumes its 8-bit per-cycle state code.
- Owns the program counter (PC), instruction register (IR), memory address register (MAR), call temp register (TMP) and stack pointer (SP).
- Drives the RAM address, plus the write strobe and write data used for CALL pushes.
- State codes are the STATE_* constants from the shared CPU parameter header.

Parameters:
- SP_INIT, 8'hFF, SP value after reset; the stack grows downward.
- PC_INIT, 8'h00, PC value after reset.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset_n  input  1  synchronous, active-low reset.
- state  input  8  current control state code from the control sequencer.
- flag_z  input  1  ALU zero flag.
- flag_c  input  1  ALU carry flag.
- mem_rdata  input  8  RAM read data; a combinational function of mem_addr.
- mem_addr  output  8  RAM address, equal to MAR.
- mem_we  output  1  RAM write strobe; registered.
- mem_wdata  output  8  RAM write data; registered.
- opcode  output  8  IR contents, fed to the control sequencer.
- pc  output  8  current PC, for debug and display.
- sp  output  8  current SP.
- halted  output  1  sticky halt indicator.
- stack_fault  output  1  sticky stack error (see Optional Feature).

Behaviour:
- Reset (reset_n low at a clk edge): PC=PC_INIT, SP=SP_INIT, MAR=0, IR=0, TMP=0, mem_we=0, mem_wdata=0, halted=0, stack_fault=0. Reset overrides any state code, including mid-CALL.
- Default every cycle: mem_we=0.
- Each edge applies exactly one action, selected by the state code sampled at that edge. All PC/SP arithmetic is 8-bit modulo 256.
- STATE_FETCH_PC: MAR<=PC.
- STATE_FETCH_INST: IR<=mem_rdata; PC<=PC+1.
- STATE_JUMP: evaluate the condition from IR[2:0]:
  - 000 always; 001 Z=1; 010 Z=0; 011 C=1; 100 C=0; other codes never taken.
  - Taken: PC<=mem_rdata. Not taken: PC<=PC+1, skipping the operand byte.
- STATE_LDI: PC<=PC+1. The operand is consumed by the register file.
- STATE_TMP_STORE: TMP<=mem_rdata; PC<=PC+1.
- STATE_FETCH_SP:
  - If IR is a RET opcode: MAR<=SP.
  - Otherwise (CALL): MAR<=SP, mem_wdata<=PC.
- STATE_PC_STORE: mem_we<=1 for exactly one cycle, writing mem_wdata to MAR; SP<=SP-1.
- STATE_TMP_JUMP: PC<=TMP.
- STATE_INC_SP: SP<=SP+1.
- STATE_RET: PC<=mem_rdata.
- STATE_HALT: halted<=1. Once set, PC, SP, IR, MAR and TMP freeze until reset. State codes are ignored while halted.
- STATE_NEXT, STATE_OUT_A, STATE_MOV_*, STATE_ALU_OP and any unknown code: no register changes.
- Wrap-around:
  - PC=8'hFF incrementing gives 8'h00.
  - SP=8'h00 decrementing gives 8'hFF, unless the stack guard is enabled.
- Latency: opcode is valid the cycle after FETCH_INST. A jump target is visible on pc the cycle after JUMP or TMP_JUMP.
- mem_addr always equals MAR; no combinational path from state to outputs.

Optional Feature:
- Macro CPU_FETCH_STACK_GUARD_EN.
- Defined:
  - STATE_PC_STORE with SP==8'h00: write and decrement are suppressed (mem_we stays 0); stack_fault<=1.
  - STATE_INC_SP with SP==8'hFF: the increment is suppressed; stack_fault<=1.
  - stack_fault is sticky until reset.
- Undefined: SP wraps silently; stack_fault is tied to 0.

Test Plan:
- Reset then fetch: mem[0]=8'h3A; states FETCH_PC, FETCH_INST -> opcode=8'h3A, pc=8'h01, mem_addr=8'h00.
- Conditional jump: IR[2:0]=001, mem_rdata=8'h40.
  - flag_z=1, JUMP -> pc=8'h40.
  - flag_z=0, PC=8'h05 -> pc=8'h06.
- CALL sequence: PC=8'h10, SP=8'hFF, mem_rdata=8'h80; TMP_STORE, FETCH_SP, PC_STORE, TMP_JUMP -> single mem_we pulse writing 8'h11 to 8'hFF; sp=8'hFE; pc=8'h80.
- RET sequence: SP=8'hFE, mem[8'hFF]=8'h11; INC_SP, FETCH_SP, RET -> sp=8'hFF, pc=8'h11.
- Halt and reset:
  - HALT then FETCH_INST -> halted=1, pc unchanged.
  - reset_n low one edge -> all outputs at reset values, halted=0.
  - reset_n asserted between TMP_STORE and PC_STORE -> no mem_we pulse, sp=SP_INIT.
- Guard: SP=8'h00 with PC_STORE -> with CPU_FETCH_STACK_GUARD_EN, mem_we=0, sp=8'h00, stack_fault=1; without it, mem_we pulses and sp=8'hFF.
